// File: rtl/fx2_fifo_arbiter.sv
// FPGA-side master for the FX2 slave-FIFO bus: shares fd between the EP2 command
// read path and the EP6 data write path with round-robin arbitration and turnaround.
module fx2_fifo_arbiter #(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [1:0]  EP_RD_ADR = 2'b00,
  parameter logic [1:0]  EP_WR_ADR = 2'b10
) (
  input  logic       ifclk,
  input  logic       reset_n,
  input  logic [7:0] fd_in,
  output logic [7:0] fd_out,
  output logic       fd_oe,
  output logic       sloe,
  output logic       slrd,
  output logic       slwr,
  output logic       pktend,
  output logic [1:0] fifoadr,
  input  logic [3:0] flags,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_flush,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Streams: a byte moves on a rising edge where valid && ready; valid never waits
  // on ready, and data is held stable while valid && !ready.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_TURN = 3'd1,
    S_RD      = 3'd2,
    S_WR_TURN = 3'd3,
    S_WR      = 3'd4,
    S_PKTEND  = 3'd5
  } state_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_e     state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] cmd_data_q, cmd_data_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       flush_pending_q, flush_pending_d;
  logic       last_grant_wr_q, last_grant_wr_d;
  logic [1:0] fifoadr_q, fifoadr_d;

  logic ep2_empty;
  logic ep6_full;
  logic rd_req;
  logic wr_req;
  logic grant_rd;
  logic grant_wr;
  logic cmd_free;
  logic burst_ok;
  logic rd_go;
  logic wr_go;
  logic unused_flags;

  assign ep2_empty    = flags[0];
  assign ep6_full     = flags[1];
  assign unused_flags = ^flags[3:2];

  assign rd_req   = !ep2_empty && !cmd_valid_q;
  assign wr_req   = (tx_valid && !ep6_full) || flush_pending_q;
  assign cmd_free = !cmd_valid_q || cmd_ready;
  assign burst_ok = burst_q < MAX_B;
  assign rd_go    = (state_q == S_RD) && !ep2_empty && cmd_free && burst_ok;
  assign wr_go    = (state_q == S_WR) && tx_valid && !ep6_full && burst_ok;

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On contention the side that did not win last time gets the bus.
        if (rd_req && wr_req) begin
          grant_rd = last_grant_wr_q;
          grant_wr = !last_grant_wr_q;
        end else begin
          grant_rd = rd_req;
          grant_wr = wr_req;
        end
        if (grant_rd) begin
          state_d = S_RD_TURN;
        end else if (grant_wr) begin
          state_d = S_WR_TURN;
        end
      end
      S_RD_TURN: state_d = S_RD;
      S_RD: begin
        if (!rd_go) begin
          state_d = S_IDLE;
        end
      end
      S_WR_TURN: state_d = S_WR;
      S_WR: begin
        if (!wr_go) begin
          state_d = (flush_pending_q && !tx_valid) ? S_PKTEND : S_IDLE;
        end
      end
      S_PKTEND: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    burst_d         = burst_q;
    cmd_data_d      = cmd_data_q;
    cmd_valid_d     = cmd_valid_q;
    flush_pending_d = flush_pending_q;
    last_grant_wr_d = last_grant_wr_q;
    fifoadr_d       = fifoadr_q;

    if (grant_rd) begin
      burst_d         = 8'd0;
      last_grant_wr_d = 1'b0;
      fifoadr_d       = EP_RD_ADR;
    end else if (grant_wr) begin
      burst_d         = 8'd0;
      last_grant_wr_d = 1'b1;
      fifoadr_d       = EP_WR_ADR;
    end else if (rd_go || wr_go) begin
      burst_d = burst_q + 8'd1;
    end

    if (rd_go) begin
      cmd_data_d  = fd_in;
      cmd_valid_d = 1'b1;
    end else if (cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    // A flush arriving during PKTEND wins so it is not lost.
    if (tx_flush) begin
      flush_pending_d = 1'b1;
    end else if (state_q == S_PKTEND) begin
      flush_pending_d = 1'b0;
    end
  end

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      burst_q         <= 8'd0;
      cmd_data_q      <= 8'd0;
      cmd_valid_q     <= 1'b0;
      flush_pending_q <= 1'b0;
      last_grant_wr_q <= 1'b1;
      fifoadr_q       <= EP_RD_ADR;
    end else begin
      burst_q         <= burst_d;
      cmd_data_q      <= cmd_data_d;
      cmd_valid_q     <= cmd_valid_d;
      flush_pending_q <= flush_pending_d;
      last_grant_wr_q <= last_grant_wr_d;
      fifoadr_q       <= fifoadr_d;
    end
  end

  always_comb begin
    sloe     = 1'b0;
    fd_oe    = 1'b0;
    slrd     = 1'b0;
    slwr     = 1'b0;
    tx_ready = 1'b0;
    pktend   = 1'b0;
    fd_out   = 8'h00;
    case (state_q)
      S_RD_TURN: sloe = 1'b1;
      S_RD: begin
        sloe = 1'b1;
        slrd = rd_go;
      end
      S_WR_TURN: fd_oe = 1'b1;
      S_WR: begin
        fd_oe    = 1'b1;
        fd_out   = tx_data;
        slwr     = wr_go;
        tx_ready = wr_go;
      end
      S_PKTEND: pktend = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign fifoadr   = fifoadr_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = cmd_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// Bench for fx2_fifo_arbiter: FX2 slave-FIFO model, command/tx scoreboards,
// a scenario table and hand-written corner sequences.
module tb_fx2_fifo_arbiter;

  localparam int MAX_BURST = 16;

  logic       ifclk     = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] fd_in     = 8'h00;
  logic [3:0] flags     = 4'b0001;
  logic       cmd_ready = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_flush  = 1'b0;
  logic [7:0] fd_out;
  logic       fd_oe, sloe, slrd, slwr, pktend;
  logic [1:0] fifoadr;
  logic [7:0] cmd_data;
  logic       cmd_valid, tx_ready, busy;
  logic [2:0] state_dbg;

  fx2_fifo_arbiter #(
    .MAX_BURST(MAX_BURST),
    .EP_RD_ADR(2'b00),
    .EP_WR_ADR(2'b10)
  ) dut (
    .ifclk(ifclk), .reset_n(reset_n), .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
    .sloe(sloe), .slrd(slrd), .slwr(slwr), .pktend(pktend), .fifoadr(fifoadr),
    .flags(flags), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 ifclk = ~ifclk;

  typedef struct {
    int         n_rd;
    logic [7:0] rd_base;
    int         n_tx;
    logic [7:0] tx_base;
    bit         flush;
    bit         rnd_ready;
    int         exp_slrd;
    int         exp_slwr;
    int         exp_pktend;
    int         exp_runs;
    int         exp_len0;
    int         exp_lead;
  } vec_t;

  vec_t vecs[6];

  int checks   = 0;
  int failures = 0;

  logic [7:0] ep2_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_tx_q[$];
  int         run_len_q[$];
  int         run_lead_q[$];
  bit         run_rd_q[$];

  bit  ep6_full  = 1'b0;
  int  full_after = 0;
  int  ep6_cnt   = 0;
  bit  rnd_ready = 1'b0;
  int  n_slrd, n_slwr, n_pktend, viol;
  bit  cap_slrd, cap_slwr, cap_txr;
  bit  in_run, run_seen, run_is_rd;
  int  cur_len, cur_lead;
  bit  prev_hold;
  logic [7:0] prev_cmd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive_pins();
    fd_in    = (ep2_q.size() != 0) ? ep2_q[0] : 8'h5A;
    flags[0] = (ep2_q.size() == 0);
    flags[1] = ep6_full;
    tx_valid = (tx_q.size() != 0);
    tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  endtask

  // FX2 side: consume strobes seen before the edge, then present new pins.
  always begin
    logic [7:0] tmp;
    @(posedge ifclk);
    #1;
    if (cap_slrd && ep2_q.size() != 0) tmp = ep2_q.pop_front();
    if (cap_txr && tx_q.size() != 0) tmp = tx_q.pop_front();
    if (cap_slwr) begin
      ep6_cnt++;
      if (full_after != 0 && ep6_cnt == full_after) ep6_full = 1'b1;
    end
    cmd_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    flags[3:2] = 2'($urandom_range(0, 3));
    drive_pins();
    #2;
    drive_pins();
  end

  // Monitor and scoreboards, sampled mid-cycle.
  always @(negedge ifclk) begin
    logic [7:0] e;
    if (!reset_n) begin
      cap_slrd = 1'b0; cap_slwr = 1'b0; cap_txr = 1'b0;
      in_run = 1'b0; prev_hold = 1'b0;
    end else begin
      cap_slrd = slrd; cap_slwr = slwr; cap_txr = tx_ready;
      if (fd_oe && sloe) viol++;
      if (slrd && slwr) viol++;
      if (slwr !== tx_ready) viol++;
      if (flags[1] && slwr) viol++;
      if (flags[0] && slrd) viol++;
      if (prev_hold && (!cmd_valid || cmd_data !== prev_cmd)) viol++;
      prev_hold = cmd_valid && !cmd_ready;
      prev_cmd  = cmd_data;
      if (slrd) n_slrd++;
      if (slwr) begin
        n_slwr++;
        if (exp_tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=%0h required=none", fd_out);
        end else begin
          e = exp_tx_q.pop_front();
          check("tx_byte", fd_out, e);
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL cmd_unexpected actual=%0h required=none", cmd_data);
        end else begin
          e = exp_cmd_q.pop_front();
          check("cmd_byte", cmd_data, e);
        end
      end
      if (pktend) begin
        n_pktend++;
        check("pktend_fifoadr", fifoadr, 2'b10);
        check("pktend_slwr", slwr, 0);
      end
      if (busy) begin
        if (!in_run) begin
          in_run = 1'b1; cur_len = 0; cur_lead = 0; run_seen = 1'b0; run_is_rd = 1'b0;
        end
        if (sloe) run_is_rd = 1'b1;
        if (slrd || slwr) begin
          cur_len++;
          run_seen = 1'b1;
        end else if (!run_seen) begin
          cur_lead++;
        end
      end else if (in_run) begin
        in_run = 1'b0;
        run_len_q.push_back(cur_len);
        run_lead_q.push_back(run_seen ? cur_lead : -1);
        run_rd_q.push_back(run_is_rd);
        check("burst_le_max", (cur_len <= MAX_BURST) ? 1 : 0, 1);
      end
    end
  end

  task automatic step();
    @(posedge ifclk);
    #2;
  endtask

  task automatic clear_stats();
    n_slrd = 0; n_slwr = 0; n_pktend = 0; viol = 0; ep6_cnt = 0;
    run_len_q.delete(); run_lead_q.delete(); run_rd_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < 600) begin
      step();
      n++;
      if (!busy && ep2_q.size() == 0 && tx_q.size() == 0 &&
          exp_cmd_q.size() == 0 && exp_tx_q.size() == 0) stable++;
      else stable = 0;
    end
    check({name, "_drain"}, (stable >= 3) ? 1 : 0, 1);
  endtask

  task automatic load(input int n_rd, input logic [7:0] rd_base,
                      input int n_tx, input logic [7:0] tx_base);
    logic [7:0] b;
    for (int i = 0; i < n_rd; i++) begin
      b = rd_base + 8'(i);
      ep2_q.push_back(b);
      exp_cmd_q.push_back(b);
    end
    for (int i = 0; i < n_tx; i++) begin
      b = tx_base + 8'(i);
      tx_q.push_back(b);
      exp_tx_q.push_back(b);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    step();
    clear_stats();
    rnd_ready = v.rnd_ready;
    load(v.n_rd, v.rd_base, v.n_tx, v.tx_base);
    if (v.flush) begin
      tx_flush = 1'b1;
      step();
      tx_flush = 1'b0;
    end
    wait_idle(p);
    rnd_ready = 1'b0;
    check({p, "_slrd"}, n_slrd, v.exp_slrd);
    check({p, "_slwr"}, n_slwr, v.exp_slwr);
    check({p, "_pktend"}, n_pktend, v.exp_pktend);
    check({p, "_protocol"}, viol, 0);
    if (v.exp_runs >= 0) check({p, "_runs"}, run_len_q.size(), v.exp_runs);
    if (v.exp_len0 >= 0 && run_len_q.size() != 0) check({p, "_len0"}, run_len_q[0], v.exp_len0);
    if (v.exp_lead >= 0 && run_lead_q.size() != 0) check({p, "_lead"}, run_lead_q[0], v.exp_lead);
  endtask

  initial begin
    int n;
    int alt_len[6];
    bit alt_rd[6];
    alt_len = '{16, 16, 16, 16, 8, 8};
    alt_rd  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    //         n_rd rd_base n_tx tx_base flush rnd  slrd slwr pkt runs len0 lead
    vecs[0] = '{3,  8'hA1,  0,  8'h00,  1'b0, 1'b0, 3,  0,  0,  1,  3,  1};
    vecs[1] = '{0,  8'h00,  20, 8'h00,  1'b0, 1'b0, 0,  20, 0,  2,  16, 1};
    vecs[2] = '{0,  8'h00,  5,  8'h40,  1'b1, 1'b0, 0,  5,  1,  1,  5,  1};
    vecs[3] = '{0,  8'h00,  0,  8'h00,  1'b1, 1'b0, 0,  0,  1,  1,  0,  -1};
    vecs[4] = '{17, 8'h10,  0,  8'h00,  1'b0, 1'b0, 17, 0,  0,  2,  16, 1};
    vecs[5] = '{10, 8'h60,  10, 8'h80,  1'b0, 1'b1, 10, 10, 0,  -1, -1, 1};

    clear_stats();
    #12;
    check("rst_fd_oe", fd_oe, 0);
    check("rst_sloe", sloe, 0);
    check("rst_slrd", slrd, 0);
    check("rst_slwr", slwr, 0);
    check("rst_pktend", pktend, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_fifoadr", fifoadr, 2'b00);
    check("rst_fd_out", fd_out, 0);
    check("rst_state", state_dbg, 0);
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // EP6 goes full after the second of eight writes, then clears.
    step();
    clear_stats();
    full_after = 2;
    load(0, 8'h00, 8, 8'hC0);
    n = 0;
    while (!ep6_full && n < 100) begin
      step();
      n++;
    end
    check("full_seen", ep6_full, 1);
    check("full_slwr", slwr, 0);
    check("full_tx_ready", tx_ready, 0);
    check("full_busy", busy, 1);
    repeat (5) step();
    check("full_idle", busy, 0);
    check("full_slwr_held", n_slwr, 2);
    ep6_full = 1'b0;
    full_after = 0;
    wait_idle("full");
    check("full_slwr", n_slwr, 8);
    check("full_runs", run_len_q.size(), 2);
    if (run_len_q.size() == 2) begin
      check("full_len0", run_len_q[0], 2);
      check("full_len1", run_len_q[1], 6);
    end
    check("full_protocol", viol, 0);

    // Reset pulsed mid-read with a command byte pending.
    step();
    clear_stats();
    load(10, 8'h20, 0, 8'h00);
    n = 0;
    while (!(slrd && cmd_valid) && n < 50) begin
      step();
      n++;
    end
    check("rstrd_reading", (slrd && cmd_valid) ? 1 : 0, 1);
    #4;
    reset_n = 1'b0;
    #1;
    check("rstrd_slrd", slrd, 0);
    check("rstrd_sloe", sloe, 0);
    check("rstrd_cmd_valid", cmd_valid, 0);
    check("rstrd_busy", busy, 0);
    check("rstrd_fifoadr", fifoadr, 2'b00);
    step();
    step();
    ep2_q.delete();
    exp_cmd_q.delete();
    step();
    reset_n = 1'b1;
    wait_idle("rstrd");
    check("rstrd_protocol", viol, 0);

    // Both sides loaded at once right after reset: RD wins first, then alternate.
    step();
    clear_stats();
    load(40, 8'h00, 40, 8'h80);
    wait_idle("alt");
    check("alt_runs", run_len_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < run_len_q.size()) begin
        check($sformatf("alt_len%0d", i), run_len_q[i], alt_len[i]);
        check($sformatf("alt_rd%0d", i), run_rd_q[i], alt_rd[i]);
      end
    end
    check("alt_slrd", n_slrd, 40);
    check("alt_slwr", n_slwr, 40);
    check("alt_protocol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
